// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU shift sequencer and the 1-bit shift unit
//   it drives.
//   - state_e    : sequencer FSM state encoding
//   - shift_op_e : shift-unit operation codes (A path and B path)
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SHR_A = 2'b00,
        SHL_A = 2'b01,
        SHR_B = 2'b10,
        SHL_B = 2'b11
    } shift_op_e;

endpackage : alu_pkg

// File: rtl/alu_shift_unit.sv
// ---------------------------------------------------------------------------
// alu_shift_unit
//   Single-bit logical shifter with one cycle of registered latency. When
//   enable is high at a rising edge, the selected operand is shifted by one
//   position (zero fill) into result, and done is set for the following
//   cycle. done is low in every cycle that does not follow an enabled edge.
//
//   Ports:
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset
//     a, b     in   operands (width bits)
//     op       in   shift_op_e code: selects operand and direction
//     enable   in   perform one shift at this edge
//     result   out  registered shifted value
//     done     out  registered completion flag
// ---------------------------------------------------------------------------
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic [1:0]       op,
    input  logic             enable,
    output logic [width-1:0] result,
    output logic             done
);

    logic [width-1:0] result_q, result_d;
    logic             done_q,   done_d;

    always_comb begin
        result_d = result_q;
        done_d   = 1'b0;
        if (enable) begin
            done_d = 1'b1;
            unique case (shift_op_e'(op))
                SHR_A:   result_d = a >> 1;
                SHL_A:   result_d = a << 1;
                SHR_B:   result_d = b >> 1;
                SHL_B:   result_d = b << 1;
                default: result_d = result_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule : alu_shift_unit

// File: rtl/alu_shift_sequencer.sv
// ---------------------------------------------------------------------------
// alu_shift_sequencer
//   Performs multi-bit logical shifts by driving a 1-bit shift unit once per
//   bit. Each iteration is an ISSUE cycle (enable pulse) followed by a WAIT
//   cycle in which the unit's registered result is captured and fed back as
//   the next operand. The final value is offered on a valid/ready result port.
//
//   Ports:
//     CLK, RST                      clock, async active-high reset
//     cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//     cmd_operand/cmd_dir/cmd_amount  value, direction (1=left), bit count
//     unit_A/unit_B/unit_op/unit_enable  request to the shift unit
//     unit_out/unit_flag            shift-unit registered result and done
//     res_valid/res_ready           result handshake
//     res_data/res_err              shifted value, missing-done fault flag
// ---------------------------------------------------------------------------
module alu_shift_sequencer
    import alu_pkg::*;
#(
    parameter int width = 16,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [width-1:0] cmd_operand,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_amount,
    output logic [width-1:0] unit_A,
    output logic [width-1:0] unit_B,
    output logic [1:0]       unit_op,
    output logic             unit_enable,
    input  logic [width-1:0] unit_out,
    input  logic             unit_flag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [width-1:0] res_data,
    output logic             res_err
);

    state_e           state_q, state_d;
    logic [width-1:0] opnd_q,  opnd_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             dir_q,   dir_d;
    logic             err_q,   err_d;

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    opnd_d  = cmd_operand;
                    dir_d   = cmd_dir;
                    cnt_d   = cmd_amount;
                    err_d   = 1'b0;
                    state_d = (cmd_amount == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (unit_flag) begin
                    opnd_d  = unit_out;
                    // cnt_q is at least 1 here: ISSUE is only reached with a
                    // nonzero count, and the loop exits when it reaches 1.
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == CNT_W'(1)) ? DONE : ISSUE;
                end else begin
                    // The unit failed to report completion; abandon the
                    // operation and report the partial result with an error.
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode directly from registered state; the unit bus is held
    // at zero outside ISSUE to keep it quiet.
    assign cmd_ready   = (state_q == IDLE);
    assign unit_enable = (state_q == ISSUE);
    assign unit_A      = unit_enable ? opnd_q : '0;
    assign unit_B      = '0;
    assign unit_op     = unit_enable ? (dir_q ? SHL_A : SHR_A) : SHR_A;
    assign res_valid   = (state_q == DONE);
    assign res_data    = res_valid ? opnd_q : '0;
    assign res_err     = res_valid & err_q;

endmodule : alu_shift_sequencer
